// File: rtl/bootprom_ctl_if.sv
// Bus bundle between the CPU-side decode, the boot PROM pair and bootprom_ctl.
//
// Handshake: the requester raises req (with wr/addr stable) and holds it
// until it sees a one-cycle ack (read data valid on rdata) or a one-cycle
// berr (write refused). The controller ignores req for at least one cycle
// after ack/berr, which gives the requester time to drop or change it.
// ack and berr are never asserted together.
interface bootprom_ctl_if;
  logic        req;
  logic        wr;
  logic [14:0] addr;
  logic        ack;
  logic        berr;
  logic [15:0] rdata;
  logic [14:0] prom_a;
  logic        prom_ce_n;
  logic        prom_oe_n;
  logic [7:0]  prom_dh;
  logic [7:0]  prom_dl;

  // Environment side: CPU decode plus the two PROM chips.
  modport master (
    output req, wr, addr, prom_dh, prom_dl,
    input  ack, berr, rdata, prom_a, prom_ce_n, prom_oe_n
  );

  // Controller side.
  modport slave (
    input  req, wr, addr, prom_dh, prom_dl,
    output ack, berr, rdata, prom_a, prom_ce_n, prom_oe_n
  );
endinterface

// File: rtl/bootprom_ctl.sv
// Boot PROM access controller for a pair of byte-wide 27256 EPROMs.
// One word read at a time: drives address/CE/OE for ACCESS_CYCLES, samples
// both byte lanes, pulses ack, then holds CE high for a recovery gap.
// Writes are refused with a one-cycle berr pulse.
//
// Optional feature macro: BOOTPROM_CACHE_EN adds a one-entry read cache
// (valid + tag) that answers a repeat read of the last address in one cycle
// without touching the PROM pins.
module bootprom_ctl #(
  parameter int ACCESS_CYCLES   = 3,
  parameter int RECOVERY_CYCLES = 1
) (
  input  logic           clk,
  input  logic           reset,
  bootprom_ctl_if.slave  bus,
  output logic [1:0]     o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_RECOVER = 2'd2
  } state_t;

  // Counter reload values; RECOVER always lasts at least one cycle.
  localparam logic [3:0] ACC_LOAD = 4'(ACCESS_CYCLES - 1);
  localparam logic [3:0] REC_LOAD = (RECOVERY_CYCLES > 1) ? 4'(RECOVERY_CYCLES - 1) : 4'd0;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_ack;
  logic        r_berr;
  logic [15:0] r_rdata;
  logic [14:0] r_prom_a;
  logic        r_ce_n;
  logic        r_oe_n;
  logic        w_hit;

`ifdef BOOTPROM_CACHE_EN
  logic        r_valid;
  logic [14:0] r_tag;

  // A hit needs a valid entry whose tag matches the requested word.
  assign w_hit = r_valid && (bus.addr == r_tag);
`else
  assign w_hit = 1'b0;
`endif

  // Main FSM: owns every output register and the shared cycle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_ack    <= 1'b0;
      r_berr   <= 1'b0;
      r_rdata  <= 16'h0000;
      r_prom_a <= 15'h0000;
      r_ce_n   <= 1'b1;
      r_oe_n   <= 1'b1;
`ifdef BOOTPROM_CACHE_EN
      r_valid  <= 1'b0;
      r_tag    <= 15'h0000;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req) begin
            if (bus.wr) begin
              // PROM space is read-only: refuse without touching the pins.
              r_berr  <= 1'b1;
              r_cnt   <= REC_LOAD;
              r_state <= S_RECOVER;
            end else if (w_hit) begin
              // Cached word is already on rdata; a single recovery cycle follows.
              r_ack   <= 1'b1;
              r_cnt   <= 4'd0;
              r_state <= S_RECOVER;
            end else begin
              r_prom_a <= bus.addr;
              r_ce_n   <= 1'b0;
              r_oe_n   <= 1'b0;
              r_cnt    <= ACC_LOAD;
              r_state  <= S_ACCESS;
            end
          end
        end

        S_ACCESS: begin
          if (r_cnt == 4'd0) begin
            r_rdata <= {bus.prom_dh, bus.prom_dl};
            r_ack   <= 1'b1;
            r_ce_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_cnt   <= REC_LOAD;
            r_state <= S_RECOVER;
`ifdef BOOTPROM_CACHE_EN
            r_valid <= 1'b1;
            r_tag   <= r_prom_a;
`endif
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end

        S_RECOVER: begin
          // ack/berr only live for the first recovery cycle; req is ignored here.
          r_ack  <= 1'b0;
          r_berr <= 1'b0;
          if (r_cnt == 4'd0) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ack       = r_ack;
  assign bus.berr      = r_berr;
  assign bus.rdata     = r_rdata;
  assign bus.prom_a    = r_prom_a;
  assign bus.prom_ce_n = r_ce_n;
  assign bus.prom_oe_n = r_oe_n;
  assign o_dbg_state   = r_state;

endmodule

// File: doc/bootprom_ctl.md
# bootprom_ctl

Boot PROM access controller between the CPU-side bus decode and the paired 27256 byte-wide boot EPROMs (high byte and low byte). It accepts one word-read request at a time, drives the shared PROM address, chip-enable and output-enable lines, and waits a fixed number of access cycles. It then samples both byte lanes, returns a 16-bit word with a one-cycle acknowledge, and enforces a recovery gap before the next access. Write attempts to the PROM space are refused with a bus-error pulse.

## Interface
- ACCESS_CYCLES, 3: cycles prom_ce_n/prom_oe_n stay low before data is sampled; legal range 1..15.
- RECOVERY_CYCLES, 1: cycles prom_ce_n stays high after an access before the next request is accepted; legal range 0..15.

- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  bus request; held high by the requester until it sees ack or berr.
- wr  in  1  1 = write attempt, 0 = read; qualified by req.
- addr  in  15  word address (CPU A15..A1).
- ack  out  1  one-cycle pulse: rdata valid for a read.
- berr  out  1  one-cycle pulse: write refused.
- rdata  out  16  {high PROM byte, low PROM byte}; holds its value between accesses.
- prom_a  out  15  address to both PROMs (A14..A0).
- prom_ce_n  out  1  chip enable to both PROMs, active low.
- prom_oe_n  out  1  output enable to both PROMs, active low.
- prom_dh  in  8  high-byte PROM data (O7..O0).
- prom_dl  in  8  low-byte PROM data (O7..O0).

## Operation
- States:
  - IDLE: waiting for a request.
  - ACCESS: PROM cycle in progress.
  - RECOVER: post-access gap.
- Reset values: state IDLE, ack=0, berr=0, rdata=16'h0000, prom_a=0, prom_ce_n=1, prom_oe_n=1, counter 0, cache valid 0.
- IDLE, req=1, wr=0:
  - load prom_a<=addr, prom_ce_n<=0, prom_oe_n<=0, counter<=ACCESS_CYCLES-1.
  - go to ACCESS.
- IDLE, req=1, wr=1:
  - berr<=1.
  - PROM pins untouched.
  - go to RECOVER.
- ACCESS:
  - counter decrements each cycle.
  - At counter==0: rdata<={prom_dh,prom_dl}, ack<=1, prom_ce_n<=1, prom_oe_n<=1, go to RECOVER.
- RECOVER:
  - lasts max(1, RECOVERY_CYCLES) cycles; ack/berr are high only in its first cycle.
  - req is ignored throughout, so the requester has one cycle to drop it.
  - Then go to IDLE.
  - A req still high on return to IDLE starts a new access.
- prom_a holds the last address while idle; it changes only on request acceptance.
- 4-bit counter; ACCESS_CYCLES and RECOVERY_CYCLES values outside their legal ranges are unsupported.

## Timing
- E0 = edge at which IDLE samples req=1.
- Read:
  - prom_ce_n/prom_oe_n low for exactly ACCESS_CYCLES cycles, starting after E0.
  - PROM data sampled at edge E0+ACCESS_CYCLES.
  - ack high during the cycle after E0+ACCESS_CYCLES.
- Write: berr high during the cycle after E0; prom_ce_n never asserted.
- Minimum prom_ce_n high time between consecutive accesses: max(1, RECOVERY_CYCLES) cycles.
- ack and berr are never high together; at most one pulse per accepted request.
- Reset mid-access: at the next edge all outputs take reset values; no ack is issued; rdata returns to 0.
- Combinational paths: none from inputs to outputs; all outputs are registered.

## Configuration
- BOOTPROM_CACHE_EN defined:
  - Adds a one-entry read cache: valid bit plus 15-bit tag, set at every completed PROM read.
  - Read in IDLE with valid && addr==tag (hit): ack at E0+1, rdata unchanged, PROM pins untouched.
  - After a hit, one RECOVER cycle, independent of RECOVERY_CYCLES.
  - Reset clears valid. Writes do not invalidate the entry (the PROM is read-only).
- BOOTPROM_CACHE_EN not defined: no cache logic; every read performs a full PROM access.

## Test plan
- Reset held 2 cycles with req=1 -> ack=0, berr=0, prom_ce_n=1, prom_oe_n=1, prom_a=0, rdata=16'h0000; no access starts while reset=1.
- Read addr 15'h0004, model drives dh=8'h4E, dl=8'h71, ACCESS_CYCLES=3 -> prom_a=15'h0004, prom_ce_n low exactly 3 cycles, single ack at E0+3 cycle, rdata=16'h4E71.
- req held high continuously, addresses 15'h0010 then 15'h0011, RECOVERY_CYCLES=1 -> two acks; prom_ce_n high for ≥1 cycle between accesses; rdata updated only on each ack.
- Write req to 15'h0100 -> one berr pulse at E0+1 cycle; ack=0, prom_ce_n=1 throughout, rdata and prom_a unchanged.
- reset asserted in the second ACCESS cycle -> no ack; prom_ce_n=1 and rdata=0 after that edge; the next read completes normally.
- Two reads of 15'h0004 back-to-back -> with BOOTPROM_CACHE_EN, second ack at E0+1 and prom_ce_n stays 1; without it, full 3-cycle access; both return 16'h4E71.
